// File: rtl/mem_rw_checker_if.sv
// mem_rw_checker_if: memory test bus shared by the pattern generator, the memory and the checker.
//   chip_sel  session enable from the generator
//   wr_en     write strobe
//   rd_en     read strobe
//   address   bus address
//   wr_data   write data driven into the memory
//   rd_data   read data returned by the memory
//   master: generator side (drives strobes, address, write data; sees read data)
//   slave:  snooping checker (every signal is an input)
interface mem_rw_checker_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              chip_sel;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    modport master (output chip_sel, wr_en, rd_en, address, wr_data, input rd_data);
    modport slave  (input chip_sel, wr_en, rd_en, address, wr_data, rd_data);
endinterface

// File: rtl/mem_rw_checker.sv
// mem_rw_checker: pairs each bus read with the preceding write to the same address, checks the returned word and reports a per-session verdict.
//   clk             single clock, rising edge
//   reset_n         asynchronous active-low reset
//   bus             memory test bus (slave modport, snooped)
//   err_pulse       one-cycle flag per data mismatch
//   err_count       saturating mismatch count for this session
//   check_count     saturating completed-compare count for this session
//   first_err_valid first_err_addr holds a capture
//   first_err_addr  address of the first mismatch
//   proto_err       sticky protocol-violation flag
//   busy            session active or draining
//   done            verdict valid
//   pass            session passed (meaningful while done)
module mem_rw_checker #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_rw_checker_if.slave     bus,
    output logic                err_pulse,
    output logic [CNT_W-1:0]    err_count,
    output logic [CNT_W-1:0]    check_count,
    output logic                first_err_valid,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic                proto_err,
    output logic                busy,
    output logic                done,
    output logic                pass
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t                 state;
    logic                   exp_valid;
    logic [ADDR_W-1:0]      exp_addr;
    logic [DATA_W-1:0]      exp_data;
    logic [RD_LATENCY-1:0]  pipe_v;
    logic [ADDR_W-1:0]      pipe_a [RD_LATENCY];
    logic [DATA_W-1:0]      pipe_d [RD_LATENCY];
    logic                   strobe_ok, wr, rd, both, hit, exit_v, mismatch;
    always_comb begin
        strobe_ok = state == ACTIVE && bus.chip_sel;
        wr        = strobe_ok && bus.wr_en && !bus.rd_en;
        rd        = strobe_ok && bus.rd_en && !bus.wr_en;
        both      = strobe_ok && bus.wr_en && bus.rd_en;
        hit       = rd && exp_valid && bus.address == exp_addr;
        exit_v    = pipe_v[RD_LATENCY-1];
        mismatch  = exit_v && bus.rd_data != pipe_d[RD_LATENCY-1];
    end
    // Compare pipeline: a hit enters stage 0 and reaches the last stage exactly
    // when the memory presents its read data, whatever the session state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= hit;
            for (int i = 1; i < RD_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end
    always_ff @(posedge clk) begin
        pipe_a[0] <= bus.address;
        pipe_d[0] <= exp_data;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            exp_valid       <= 1'b0;
            exp_addr        <= '0;
            exp_data        <= '0;
            err_pulse       <= 1'b0;
            err_count       <= '0;
            check_count     <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
            proto_err       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            err_pulse <= mismatch;
            if (exit_v && check_count != CNT_MAX) check_count <= check_count + 1'b1;
            if (mismatch) begin
                if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= pipe_a[RD_LATENCY-1];
                end
            end
            if (wr) begin
                exp_valid <= 1'b1;
                exp_addr  <= bus.address;
                exp_data  <= bus.wr_data;
            end
            if (hit) exp_valid <= 1'b0;
            if ((rd && !hit) || both) proto_err <= 1'b1;
            // The pipeline is always empty in IDLE/DONE, so the session clear
            // below never collides with a compare update.
            case (state)
                IDLE, DONE: if (bus.chip_sel) begin
                    state           <= ACTIVE;
                    busy            <= 1'b1;
                    done            <= 1'b0;
                    pass            <= 1'b0;
                    err_count       <= '0;
                    check_count     <= '0;
                    first_err_valid <= 1'b0;
                    first_err_addr  <= '0;
                    proto_err       <= 1'b0;
                    exp_valid       <= 1'b0;
                end
                ACTIVE: if (!bus.chip_sel) state <= DRAIN;
                DRAIN: if (!(|pipe_v)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= err_count == '0 && !proto_err && check_count != '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_rw_checker.sv
// tb_mem_rw_checker: scoreboard bench driving two checkers (latency 1 / 16-bit counters and latency 4 / 4-bit counters) from one generator.
module tb_mem_rw_checker;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [10:0] addr = '0;
    logic [15:0] wdata = '0;
    int          fault_mode = 0;
    int          n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;

    mem_rw_checker_if #(.ADDR_W(11), .DATA_W(16)) b0 ();
    mem_rw_checker_if #(.ADDR_W(11), .DATA_W(16)) b1 ();
    logic [15:0] mem [2048];
    logic [15:0] mp0;
    logic [15:0] mp1 [4];
    assign b0.chip_sel = cs;    assign b1.chip_sel = cs;
    assign b0.wr_en    = wr;    assign b1.wr_en    = wr;
    assign b0.rd_en    = rd;    assign b1.rd_en    = rd;
    assign b0.address  = addr;  assign b1.address  = addr;
    assign b0.wr_data  = wdata; assign b1.wr_data  = wdata;
    assign b0.rd_data  = mp0;
    assign b1.rd_data  = mp1[3];

    function automatic logic [15:0] model_rd(input logic [10:0] a);
        logic flip;
        flip = fault_mode == 2 || (fault_mode == 1 && (a == 11'h005 || a == 11'h3A0));
        return mem[a] ^ {15'd0, flip};
    endfunction

    // Memory model: echoes written data after 1 (b0) or 4 (b1) clocks.
    always @(posedge clk) begin
        if (cs && wr && !rd) mem[addr] <= wdata;
        mp0    <= model_rd(addr);
        mp1[0] <= model_rd(addr);
        for (int i = 1; i < 4; i++) mp1[i] <= mp1[i-1];
    end

    logic        ep [2], fev [2], pe [2], bz [2], dn [2], ps [2];
    logic [10:0] fa [2];
    logic [15:0] ec0, cc0;
    logic [3:0]  ec1, cc1;
    int          ec [2], cc [2];
    assign ec[0] = int'(ec0);
    assign cc[0] = int'(cc0);
    assign ec[1] = int'(ec1);
    assign cc[1] = int'(cc1);

    mem_rw_checker #(.ADDR_W(11), .DATA_W(16), .RD_LATENCY(1), .CNT_W(16)) u0 (
        .clk(clk), .reset_n(reset_n), .bus(b0), .err_pulse(ep[0]), .err_count(ec0),
        .check_count(cc0), .first_err_valid(fev[0]), .first_err_addr(fa[0]),
        .proto_err(pe[0]), .busy(bz[0]), .done(dn[0]), .pass(ps[0]));
    mem_rw_checker #(.ADDR_W(11), .DATA_W(16), .RD_LATENCY(4), .CNT_W(4)) u1 (
        .clk(clk), .reset_n(reset_n), .bus(b1), .err_pulse(ep[1]), .err_count(ec1),
        .check_count(cc1), .first_err_valid(fev[1]), .first_err_addr(fa[1]),
        .proto_err(pe[1]), .busy(bz[1]), .done(dn[1]), .pass(ps[1]));

    function automatic void check(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endfunction

    typedef struct {
        int chk; int err; int fev; int faddr; int proto; int pass; int pulses;
    } exp_t;
    exp_t q0[$], q1[$];
    int   pulses [2];
    logic dn_q [2];

    // Monitor: counts err_pulse cycles and checks the verdict on each done rise.
    always @(negedge clk) begin
        exp_t e;
        bit   got;
        for (int j = 0; j < 2; j++) begin
            if (!reset_n) begin
                pulses[j] = 0;
                dn_q[j]   = 1'b0;
            end else begin
                if (ep[j]) pulses[j]++;
                if (dn[j] && !dn_q[j]) begin
                    got = 1'b1;
                    if (j == 0 && q0.size() > 0) e = q0.pop_front();
                    else if (j == 1 && q1.size() > 0) e = q1.pop_front();
                    else got = 1'b0;
                    if (!got) check($sformatf("u%0d_unexpected_done", j), 1, 0);
                    else begin
                        check($sformatf("u%0d_check_count", j), cc[j], e.chk);
                        check($sformatf("u%0d_err_count", j), ec[j], e.err);
                        check($sformatf("u%0d_first_err_valid", j), int'(fev[j]), e.fev);
                        if (e.fev != 0) check($sformatf("u%0d_first_err_addr", j), int'(fa[j]), e.faddr);
                        check($sformatf("u%0d_proto_err", j), int'(pe[j]), e.proto);
                        check($sformatf("u%0d_pass", j), int'(ps[j]), e.pass);
                        check($sformatf("u%0d_err_pulse_cycles", j), pulses[j], e.pulses);
                    end
                    pulses[j] = 0;
                end
                dn_q[j] = dn[j];
            end
        end
    end

    function automatic logic [15:0] dpat(input logic [10:0] a, input logic [15:0] s);
        return {a, 5'd0} ^ 16'h5A3C ^ s;
    endfunction

    task automatic pair(input logic [10:0] a, input logic [15:0] d, input bit idle = 1'b1);
        @(negedge clk);
        wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0; rd = 1'b1;
        if (idle) begin
            @(negedge clk);
            rd = 1'b0;
        end
    endtask

    task automatic start_session;
        @(negedge clk);
        cs = 1'b1;
    endtask

    task automatic end_session(input exp_t x0, input exp_t x1, input int lat0, input int lat1);
        int lat [2];
        q0.push_back(x0);
        q1.push_back(x1);
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; rd = 1'b0;
        lat[0] = 0;
        lat[1] = 0;
        for (int n = 1; n <= 20 && (lat[0] == 0 || lat[1] == 0); n++) begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) if (dn[j] && lat[j] == 0) lat[j] = n;
        end
        check("u0_done_latency", lat[0], lat0);
        check("u1_done_latency", lat[1], lat1);
    endtask

    task automatic check_zero(input string tag);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("%s_u%0d_err_pulse", tag, j), int'(ep[j]), 0);
            check($sformatf("%s_u%0d_err_count", tag, j), ec[j], 0);
            check($sformatf("%s_u%0d_check_count", tag, j), cc[j], 0);
            check($sformatf("%s_u%0d_first_err_valid", tag, j), int'(fev[j]), 0);
            check($sformatf("%s_u%0d_first_err_addr", tag, j), int'(fa[j]), 0);
            check($sformatf("%s_u%0d_proto_err", tag, j), int'(pe[j]), 0);
            check($sformatf("%s_u%0d_busy", tag, j), int'(bz[j]), 0);
            check($sformatf("%s_u%0d_done", tag, j), int'(dn[j]), 0);
            check($sformatf("%s_u%0d_pass", tag, j), int'(ps[j]), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1 check_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        // Clean sweep over every address
        start_session;
        for (int a = 0; a < 2048; a++) pair(11'(a), dpat(11'(a), 16'h0000));
        end_session(exp_t'{2048, 0, 0, 0, 0, 1, 0}, exp_t'{15, 0, 0, 0, 0, 1, 0}, 2, 4);
        // Injected single-bit faults at 0x005 and 0x3A0
        fault_mode = 1;
        start_session;
        for (int a = 0; a < 2048; a++) pair(11'(a), dpat(11'(a), 16'h1111));
        end_session(exp_t'{2048, 2, 1, 5, 0, 0, 2}, exp_t'{15, 2, 1, 5, 0, 0, 2}, 2, 4);
        fault_mode = 0;
        // Protocol errors: unmatched read address, then simultaneous strobes
        start_session;
        pair(11'h100, 16'hBEEF);
        @(negedge clk); wr = 1'b1; addr = 11'h011; wdata = 16'h1234;
        @(negedge clk); wr = 1'b0;
        @(negedge clk); rd = 1'b1; addr = 11'h010;
        @(negedge clk); rd = 1'b0;
        @(negedge clk); wr = 1'b1; rd = 1'b1; addr = 11'h030;
        @(negedge clk); wr = 1'b0; rd = 1'b0;
        end_session(exp_t'{1, 0, 0, 0, 1, 0, 0}, exp_t'{1, 0, 0, 0, 1, 0, 0}, 2, 2);
        // Final read one cycle before chip_sel falls; completes in DRAIN
        start_session;
        pair(11'h040, 16'h0F0F);
        pair(11'h041, 16'hF0F0);
        pair(11'h042, 16'h3C3C, 1'b0);
        end_session(exp_t'{3, 0, 0, 0, 0, 1, 0}, exp_t'{3, 0, 0, 0, 0, 1, 0}, 2, 5);
        // Reset mid-session, then a fresh session counts from zero
        start_session;
        for (int a = 0; a < 100; a++) pair(11'(a + 11'h400), dpat(11'(a), 16'h2222));
        @(negedge clk);
        reset_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0;
        #1 check_zero("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        start_session;
        for (int a = 0; a < 3; a++) pair(11'(a + 11'h7FE), dpat(11'(a), 16'h3333));
        end_session(exp_t'{3, 0, 0, 0, 0, 1, 0}, exp_t'{3, 0, 0, 0, 0, 1, 0}, 2, 4);
        // Twenty mismatches saturate the 4-bit counters
        fault_mode = 2;
        start_session;
        for (int a = 0; a < 20; a++) pair(11'(a + 11'h200), dpat(11'(a), 16'h4444));
        end_session(exp_t'{20, 20, 1, 11'h200, 0, 0, 20}, exp_t'{15, 15, 1, 11'h200, 0, 0, 20}, 2, 4);
        fault_mode = 0;
        // Re-arm from DONE clears statistics and the verdict
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            check($sformatf("rearm_u%0d_done", j), int'(dn[j]), 0);
            check($sformatf("rearm_u%0d_pass", j), int'(ps[j]), 0);
            check($sformatf("rearm_u%0d_err_count", j), ec[j], 0);
            check($sformatf("rearm_u%0d_check_count", j), cc[j], 0);
            check($sformatf("rearm_u%0d_first_err_valid", j), int'(fev[j]), 0);
            check($sformatf("rearm_u%0d_busy", j), int'(bz[j]), 1);
        end
        pair(11'h555, 16'hAAAA);
        pair(11'h2AA, 16'h5555);
        end_session(exp_t'{2, 0, 0, 0, 0, 1, 0}, exp_t'{2, 0, 0, 0, 0, 1, 0}, 2, 4);
        repeat (5) @(negedge clk);
        check("u0_scoreboard_left", q0.size(), 0);
        check("u1_scoreboard_left", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
